// File: rtl/ro_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ro_meter_pkg;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StSendHi,
        StSendLo
    } meter_state_t;

    // Width of one byte on the output stream
    localparam int unsigned BYTE_W = 8;

    // Legal edge-counter widths: the result must need two bytes but fit in two bytes
    localparam int unsigned CNT_W_MIN = 9;
    localparam int unsigned CNT_W_MAX = 16;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer chain for an asynchronous input followed by a registered
// rising-edge pulse. The pulse lags the input edge by SYNC_STAGES+1 cycles.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_d;

    // Shift the input through the synchronizer and register the edge pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            s_d  <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            s_d  <= sync[SYNC_STAGES-1];
            rise <= sync[SYNC_STAGES-1] & ~s_d;
        end
    end

endmodule

// File: rtl/ro_freq_meter.sv
// Gated frequency counter: counts oscillator rising edges over a window of clk
// cycles, latches the result and streams it out as two bytes, MSB first.
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int unsigned WINDOW_W    = 16,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                osc_in,
    input  logic                start,
    input  logic [WINDOW_W-1:0] window_len,
    output logic                busy,
    output logic [6:0]          count_live,
    output logic [CNT_W-1:0]    count_q,
    output logic                saturated,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BYTE_W-1:0]   out_data
);

    localparam int unsigned    EXT_W   = 2 * BYTE_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meter_state_t        state;
    logic [WINDOW_W-1:0] win;
    logic [CNT_W-1:0]    cnt;
    logic                sat;
    logic                edge_pulse;

    logic [CNT_W-1:0]    cnt_next;
    logic                sat_next;
    logic [EXT_W-1:0]    cnt_ext;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk (clk),
        .rst (rst),
        .din (osc_in),
        .rise(edge_pulse)
    );

    // Saturating increment; the zero-extended copy supplies the MSB byte
    always_comb begin
        cnt_next = cnt;
        sat_next = sat;
        if (edge_pulse) begin
            if (cnt == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
        cnt_ext = EXT_W'(cnt_next);
    end

    assign count_live = cnt[6:0];

    // Measurement sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            win       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            busy      <= 1'b0;
            count_q   <= '0;
            saturated <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        cnt  <= '0;
                        sat  <= 1'b0;
                        win  <= window_len;
                        busy <= 1'b1;
                        if (window_len == '0) begin
                            // Empty window: report a zero count immediately
                            count_q   <= '0;
                            saturated <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= '0;
                            state     <= StSendHi;
                        end else begin
                            state <= StCount;
                        end
                    end
                end
                StCount: begin
                    cnt <= cnt_next;
                    sat <= sat_next;
                    win <= win - WINDOW_W'(1);
                    if (win == WINDOW_W'(1)) begin
                        // Last window cycle: include this cycle's edge in the result
                        count_q   <= cnt_next;
                        saturated <= sat_next;
                        out_valid <= 1'b1;
                        out_data  <= cnt_ext[EXT_W-1:BYTE_W];
                        state     <= StSendHi;
                    end
                end
                StSendHi: begin
                    if (out_ready) begin
                        out_data <= count_q[BYTE_W-1:0];
                        state    <= StSendLo;
                    end
                end
                StSendLo: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: a 16-bit and a 9-bit counter instance share stimulus.
`timescale 1ns/1ps
module tb_ro_freq_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        osc_in = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] window_len = '0;

    logic        busy_a, saturated_a, out_valid_a;
    logic [6:0]  count_live_a;
    logic [15:0] count_q_a;
    logic [7:0]  out_data_a;

    logic        busy_b, saturated_b, out_valid_b;
    logic [6:0]  count_live_b;
    logic [8:0]  count_q_b;
    logic [7:0]  out_data_b;

    int vectors = 0;
    int miscompares = 0;

    bit osc_en = 1'b0;
    int osc_half = 50;

    ro_freq_meter #(.WINDOW_W(16), .CNT_W(16), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .window_len(window_len),
        .busy(busy_a), .count_live(count_live_a), .count_q(count_q_a),
        .saturated(saturated_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a)
    );

    ro_freq_meter #(.WINDOW_W(16), .CNT_W(9), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .osc_in(osc_in), .start(start), .window_len(window_len),
        .busy(busy_b), .count_live(count_live_b), .count_q(count_q_b),
        .saturated(saturated_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b)
    );

    always #5 clk = ~clk;

    // Oscillator model, deliberately offset from the clk edges
    always begin
        if (osc_en) begin
            #(osc_half) osc_in = ~osc_in;
        end else begin
            osc_in = 1'b0;
            #7;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns in cycle T+1
    task automatic pulse_start(input logic [15:0] len);
        window_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycles until out_valid_a rises, -1 if it never does within bound
    task automatic wait_valid(input int bound, output int cyc);
        cyc = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (out_valid_a) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        osc_en = 1'b1;
        osc_half = 20;
        repeat (3) tick();
        vectors++;
        if ({busy_a, out_valid_a, saturated_a} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags_a got %b want 000", {busy_a, out_valid_a, saturated_a});
        end
        vectors++;
        if (count_live_a !== 7'd0 || count_q_a !== 16'd0 || out_data_a !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_values_a live=%0d q=%0d data=%0d want 0 0 0",
                     count_live_a, count_q_a, out_data_a);
        end
        vectors++;
        if ({busy_b, out_valid_b, saturated_b} !== 3'b000 || count_q_b !== 9'd0
            || count_live_b !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_b flags=%b q=%0d live=%0d want 000 0 0",
                     {busy_b, out_valid_b, saturated_b}, count_q_b, count_live_b);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_count();
        int cyc;
        osc_en = 1'b1;
        osc_half = 50;
        out_ready = 1'b1;
        pulse_start(16'd100);
        vectors++;
        if (busy_a !== 1'b1 || out_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy busy=%b valid=%b want 1 0", busy_a, out_valid_a);
        end
        wait_valid(150, cyc);
        vectors++;
        if (cyc !== 100) begin
            miscompares++;
            $display("FAIL basic_latency got T+%0d want T+101", cyc + 1);
        end
        vectors++;
        if (!(count_q_a >= 16'd9 && count_q_a <= 16'd11) || saturated_a !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_count q=%0d sat=%b want 10+-1 0", count_q_a, saturated_a);
        end
        vectors++;
        if (out_data_a !== 8'h00) begin
            miscompares++;
            $display("FAIL basic_msb got %h want 00", out_data_a);
        end
        tick();
        vectors++;
        if (out_valid_a !== 1'b1 || !(out_data_a >= 8'd9 && out_data_a <= 8'd11)) begin
            miscompares++;
            $display("FAIL basic_lsb valid=%b data=%h want 1 0a+-1", out_valid_a, out_data_a);
        end
        tick();
        vectors++;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b0 ||
            !(count_live_a >= 7'd9 && count_live_a <= 7'd11)) begin
            miscompares++;
            $display("FAIL basic_done valid=%b busy=%b live=%0d want 0 0 10+-1",
                     out_valid_a, busy_a, count_live_a);
        end
    endtask

    task automatic test_saturation();
        int cyc;
        osc_en = 1'b1;
        osc_half = 20;
        out_ready = 1'b1;
        pulse_start(16'd4000);
        wait_valid(4100, cyc);
        vectors++;
        if (cyc !== 4000) begin
            miscompares++;
            $display("FAIL sat_latency got T+%0d want T+4001", cyc + 1);
        end
        vectors++;
        if (count_q_b !== 9'd511 || saturated_b !== 1'b1 || out_data_b !== 8'h01) begin
            miscompares++;
            $display("FAIL sat_result q=%0d sat=%b msb=%h want 511 1 01",
                     count_q_b, saturated_b, out_data_b);
        end
        vectors++;
        if (!(count_q_a >= 16'd999 && count_q_a <= 16'd1001) || saturated_a !== 1'b0
            || out_data_a !== 8'h03) begin
            miscompares++;
            $display("FAIL wide_result q=%0d sat=%b msb=%h want 1000+-1 0 03",
                     count_q_a, saturated_a, out_data_a);
        end
        tick();
        vectors++;
        if (out_data_b !== 8'hFF || out_valid_b !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_lsb data=%h valid=%b want ff 1", out_data_b, out_valid_b);
        end
        tick();
        vectors++;
        if (busy_b !== 1'b0 || out_valid_b !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_done busy=%b valid=%b want 0 0", busy_b, out_valid_b);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        int xfers;
        osc_en = 1'b1;
        osc_half = 20;
        out_ready = 1'b0;
        pulse_start(16'd2000);
        wait_valid(2100, cyc);
        vectors++;
        if (cyc !== 2000) begin
            miscompares++;
            $display("FAIL bp_latency got T+%0d want T+2001", cyc + 1);
        end
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (out_valid_a !== 1'b1 || out_data_a !== 8'h01) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d valid=%b data=%h want 1 01",
                         i, out_valid_a, out_data_a);
            end
            tick();
        end
        out_ready = 1'b1;
        xfers = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid_a && out_ready) xfers++;
            tick();
        end
        vectors++;
        if (xfers !== 2 || busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_transfers got %0d busy=%b want 2 0", xfers, busy_a);
        end
    endtask

    task automatic test_zero_window();
        osc_en = 1'b0;
        out_ready = 1'b1;
        tick();
        pulse_start(16'd0);
        vectors++;
        if (out_valid_a !== 1'b1 || out_data_a !== 8'h00 || count_q_a !== 16'd0
            || busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_msb valid=%b data=%h q=%0d busy=%b want 1 00 0 1",
                     out_valid_a, out_data_a, count_q_a, busy_a);
        end
        tick();
        vectors++;
        if (out_valid_a !== 1'b1 || out_data_a !== 8'h00) begin
            miscompares++;
            $display("FAIL zero_lsb valid=%b data=%h want 1 00", out_valid_a, out_data_a);
        end
        tick();
        vectors++;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done valid=%b busy=%b want 0 0", out_valid_a, busy_a);
        end
    endtask

    task automatic test_ignored_start();
        int cyc;
        osc_en = 1'b0;
        out_ready = 1'b0;
        pulse_start(16'd30);
        repeat (9) tick();
        // Cycle T+10, inside COUNT
        window_len = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        window_len = 16'd0;
        vectors++;
        if (busy_a !== 1'b1 || out_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_count busy=%b valid=%b want 1 0", busy_a, out_valid_a);
        end
        wait_valid(40, cyc);
        vectors++;
        if (cyc !== 20) begin
            miscompares++;
            $display("FAIL ign_window got T+%0d want T+31", cyc + 11);
        end
        window_len = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (out_valid_a !== 1'b1 || out_data_a !== 8'h00) begin
            miscompares++;
            $display("FAIL ign_sendhi valid=%b data=%h want 1 00", out_valid_a, out_data_a);
        end
        out_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid_a !== 1'b0 || busy_a !== 1'b0) begin
                miscompares++;
                $display("FAIL ign_restart cycle %0d valid=%b busy=%b want 0 0",
                         i, out_valid_a, busy_a);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_count();
        bit seen;
        osc_en = 1'b1;
        osc_half = 50;
        out_ready = 1'b1;
        pulse_start(16'd100);
        repeat (49) tick();
        vectors++;
        if (!(count_live_a >= 7'd3 && count_live_a <= 7'd6)) begin
            miscompares++;
            $display("FAIL mid_live got %0d want 3..6", count_live_a);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({busy_a, out_valid_a, saturated_a} !== 3'b000 || count_live_a !== 7'd0
            || count_q_a !== 16'd0 || out_data_a !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_reset flags=%b live=%0d q=%0d data=%h want 000 0 0 00",
                     {busy_a, out_valid_a, saturated_a}, count_live_a, count_q_a, out_data_a);
        end
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (out_valid_a || out_valid_b || busy_a) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_no_output got activity=%b want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_saturation();
        test_backpressure();
        test_zero_window();
        test_ignored_start();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
